// File: rtl/lpif_asym_link_sync_pkg.sv
// Shared types and constants for the asymmetric LPIF link sequencer.
//   tx_state_e  : TX sequencer states; the encoding is also the debug_status state field
//   DBG_*       : bit positions inside the 32-bit debug_status word
//   pack_debug  : builds debug_status from the live status fields
package lpif_asym_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_DLY_X  = 2'd1,
        TX_SYNC   = 2'd2,
        TX_ONLINE = 2'd3
    } tx_state_e;

    localparam int unsigned CREDIT_WIDTH   = 8;
    localparam int unsigned DBG_CREDIT_LSB = 24;
    localparam int unsigned DBG_TXST_LSB   = 20;
    localparam int unsigned DBG_TXDLY_BIT  = 19;
    localparam int unsigned DBG_RXDLY_BIT  = 18;
    localparam int unsigned DBG_UFL_BIT    = 17;
    localparam int unsigned DBG_OFL_BIT    = 16;

    function automatic logic [31:0] pack_debug(
        input logic [CREDIT_WIDTH-1:0] credit,
        input tx_state_e               st,
        input logic                    tx_dly,
        input logic                    rx_dly,
        input logic                    ufl,
        input logic                    ofl
    );
        logic [31:0] w;
        w = '0;
        w[DBG_CREDIT_LSB +: CREDIT_WIDTH] = credit;
        w[DBG_TXST_LSB +: 2]              = st;
        w[DBG_TXDLY_BIT]                  = tx_dly;
        w[DBG_RXDLY_BIT]                  = rx_dly;
        w[DBG_UFL_BIT]                    = ufl;
        w[DBG_OFL_BIT]                    = ofl;
        return w;
    endfunction

endpackage

// File: rtl/lpif_asym_link_sync_if.sv
// Control/status bundle between the user/configuration side and the link sequencer.
//   master : user side - drives online controls, delays, userbit patterns, credit events
//   slave  : sequencer - drives the qualified online flags, gated userbits, credit
//            availability and the debug word
interface lpif_asym_link_sync_if #(
    parameter int unsigned MARKER_WIDTH = 4,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                    tx_online;
    logic                    rx_online;
    logic                    rx_online_holdoff;
    logic [CNT_WIDTH-1:0]    delay_x_value;
    logic [CNT_WIDTH-1:0]    delay_y_value;
    logic [CNT_WIDTH-1:0]    delay_z_value;
    logic [MARKER_WIDTH-1:0] tx_mrk_userbit;
    logic                    tx_stb_userbit;
    logic [7:0]              init_downstream_credit;
    logic                    tx_push;
    logic                    credit_return;
    logic                    tx_online_delay;
    logic                    rx_online_delay;
    logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit;
    logic                    tx_auto_stb_userbit;
    logic                    tx_credit_avail;
    logic [31:0]             debug_status;

    modport master (
        output tx_online, rx_online, rx_online_holdoff,
               delay_x_value, delay_y_value, delay_z_value,
               tx_mrk_userbit, tx_stb_userbit, init_downstream_credit,
               tx_push, credit_return,
        input  tx_online_delay, rx_online_delay, tx_auto_mrk_userbit,
               tx_auto_stb_userbit, tx_credit_avail, debug_status
    );

    modport slave (
        input  tx_online, rx_online, rx_online_holdoff,
               delay_x_value, delay_y_value, delay_z_value,
               tx_mrk_userbit, tx_stb_userbit, init_downstream_credit,
               tx_push, credit_return,
        output tx_online_delay, rx_online_delay, tx_auto_mrk_userbit,
               tx_auto_stb_userbit, tx_credit_avail, debug_status
    );
endinterface

// File: rtl/lpif_asym_link_sync_delay_cnt.sv
// Up-counter used to time one delay phase.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous clear to zero (wins over enable)
//   enable   : advance the count by one this cycle
//   limit    : phase length threshold, may change at any time
//   done     : count has reached or passed limit
module lpif_asym_delay_cnt #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 done
);
    logic [CNT_WIDTH-1:0] count;

    // Saturates at all-ones so a long stall never wraps back below the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // ">=" so that lowering the limit below the count ends the phase at once.
    assign done = (count >= limit);

endmodule

// File: rtl/lpif_asym_link_sync.sv
// Online sequencer and downstream credit tracker for the asymmetric LPIF TX/RX tops.
//   clk_wr : single clock
//   rst_wr : asynchronous active-high reset
//   lnk    : control/status bundle (slave side), see lpif_asym_link_sync_if
// TX: IDLE -> DLY_X -> SYNC -> ONLINE, markers/strobe gated by state, online qualifier
// in ONLINE. RX: online qualifier after a holdoff-restartable delay. Credits: 8-bit
// saturating counter with sticky underflow/overflow flags, live only in ONLINE.
module lpif_asym_link_sync
    import lpif_asym_pkg::*;
#(
    parameter int unsigned MARKER_WIDTH      = 4,
    parameter bit          PERSISTENT_MARKER = 1'b1,
    parameter bit          PERSISTENT_STROBE = 1'b1,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    lpif_asym_link_sync_if.slave lnk
);
    tx_state_e                state, state_next;
    logic                     tx_cnt_clear, tx_cnt_en, tx_cnt_done, tx_phase_done;
    logic [CNT_WIDTH-1:0]     tx_limit;
    logic                     rx_run, rx_armed, rx_cnt_done, rx_dly;
    logic [CREDIT_WIDTH-1:0]  credit;
    logic                     ufl, ofl, enter_online;
    logic                     mrk_on, stb_on;

    // ---------------- TX sequencer ----------------
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) state <= TX_IDLE;
        else        state <= state_next;
    end

    // DLY_X lasts X+1 cycles (entry edge included) but SYNC must last exactly Y cycles,
    // so SYNC compares against Y-1 and Y=0 skips SYNC altogether.
    always_comb begin
        tx_limit      = lnk.delay_x_value;
        tx_phase_done = tx_cnt_done;
        if (state == TX_SYNC) begin
            if (lnk.delay_y_value == '0) tx_phase_done = 1'b1;
            else                         tx_limit = lnk.delay_y_value - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:   if (lnk.tx_online) state_next = TX_DLY_X;
            TX_DLY_X:  if (tx_phase_done)
                           state_next = (lnk.delay_y_value == '0) ? TX_ONLINE : TX_SYNC;
            TX_SYNC:   if (tx_phase_done) state_next = TX_ONLINE;
            TX_ONLINE: state_next = TX_ONLINE;
            default:   state_next = TX_IDLE;
        endcase
        if (!lnk.tx_online) state_next = TX_IDLE;
    end

    assign tx_cnt_clear = (state_next != state) || (state == TX_IDLE);
    assign tx_cnt_en    = (state == TX_DLY_X) || (state == TX_SYNC);

    lpif_asym_delay_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_tx_cnt (
        .clk    (clk_wr),
        .rst    (rst_wr),
        .clear  (tx_cnt_clear),
        .enable (tx_cnt_en),
        .limit  (tx_limit),
        .done   (tx_cnt_done)
    );

    // ---------------- RX qualifier ----------------
    // The first edge with rx_online high only arms the counter; holdoff clears the
    // count but keeps it armed, so a restart costs exactly the cycles already counted.
    assign rx_run = lnk.rx_online && !lnk.rx_online_holdoff;

    lpif_asym_delay_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rx_cnt (
        .clk    (clk_wr),
        .rst    (rst_wr),
        .clear  (!rx_run),
        .enable (rx_run && rx_armed),
        .limit  (lnk.delay_z_value),
        .done   (rx_cnt_done)
    );

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            rx_armed <= 1'b0;
            rx_dly   <= 1'b0;
        end else begin
            rx_armed <= lnk.rx_online;
            if (!lnk.rx_online)                        rx_dly <= 1'b0;
            else if (rx_run && rx_armed && rx_cnt_done) rx_dly <= 1'b1;
        end
    end

    // ---------------- Downstream credits ----------------
    assign enter_online = (state_next == TX_ONLINE) && (state != TX_ONLINE);

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            credit <= '0;
            ufl    <= 1'b0;
            ofl    <= 1'b0;
        end else if (state_next == TX_IDLE) begin
            credit <= '0;
            ufl    <= 1'b0;
            ofl    <= 1'b0;
        end else if (enter_online) begin
            credit <= lnk.init_downstream_credit;
        end else if (state == TX_ONLINE) begin
            if (lnk.tx_push && !lnk.credit_return) begin
                if (credit != '0) credit <= credit - CREDIT_WIDTH'(1);
                else              ufl    <= 1'b1;
            end else if (lnk.credit_return && !lnk.tx_push) begin
                if (credit != '1) credit <= credit + CREDIT_WIDTH'(1);
                else              ofl    <= 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign mrk_on = (state == TX_SYNC) || ((state == TX_ONLINE) && PERSISTENT_MARKER);
    assign stb_on = (state == TX_SYNC) || ((state == TX_ONLINE) && PERSISTENT_STROBE);

    assign lnk.tx_online_delay     = (state == TX_ONLINE);
    assign lnk.rx_online_delay     = rx_dly;
    assign lnk.tx_auto_mrk_userbit = mrk_on ? lnk.tx_mrk_userbit : '0;
    assign lnk.tx_auto_stb_userbit = stb_on & lnk.tx_stb_userbit;
    assign lnk.tx_credit_avail     = (state == TX_ONLINE) && (credit != '0);
    assign lnk.debug_status        = pack_debug(credit, state, state == TX_ONLINE,
                                                rx_dly, ufl, ofl);

endmodule

// File: tb/tb_lpif_asym_link_sync.sv
// Bench for lpif_asym_link_sync: two instances (quarter-rate persistent, half-rate
// non-persistent) share one stimulus and one timing model based on edge counts.
module tb_lpif_asym_link_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lpif_asym_link_sync_if #(.MARKER_WIDTH(4), .CNT_WIDTH(16)) ifa ();
    lpif_asym_link_sync_if #(.MARKER_WIDTH(2), .CNT_WIDTH(16)) ifb ();

    lpif_asym_link_sync #(.MARKER_WIDTH(4), .PERSISTENT_MARKER(1'b1),
                          .PERSISTENT_STROBE(1'b1), .CNT_WIDTH(16)) u_a (
        .clk_wr (clk), .rst_wr (rst), .lnk (ifa.slave));

    lpif_asym_link_sync #(.MARKER_WIDTH(2), .PERSISTENT_MARKER(1'b0),
                          .PERSISTENT_STROBE(1'b0), .CNT_WIDTH(16)) u_b (
        .clk_wr (clk), .rst_wr (rst), .lnk (ifb.slave));

    // stimulus
    bit         tx_on, rx_on, hold, push, ret, stb;
    int         x, y, z;
    logic [3:0] mrk;
    logic [7:0] init;

    // reference model: k_tx = edges since tx_online was first sampled high (-1 = off)
    int         k_tx;
    logic [7:0] m_credit;
    bit         m_ufl, m_ofl, m_rxd, rx_armed;
    int         rx_cnt;

    int checks = 0;
    int passed = 0;
    int first_a, first_b, first_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        ifa.tx_online = tx_on;            ifb.tx_online = tx_on;
        ifa.rx_online = rx_on;            ifb.rx_online = rx_on;
        ifa.rx_online_holdoff = hold;     ifb.rx_online_holdoff = hold;
        ifa.delay_x_value = 16'(x);       ifb.delay_x_value = 16'(x);
        ifa.delay_y_value = 16'(y);       ifb.delay_y_value = 16'(y);
        ifa.delay_z_value = 16'(z);       ifb.delay_z_value = 16'(z);
        ifa.tx_mrk_userbit = mrk;         ifb.tx_mrk_userbit = mrk[1:0];
        ifa.tx_stb_userbit = stb;         ifb.tx_stb_userbit = stb;
        ifa.init_downstream_credit = init; ifb.init_downstream_credit = init;
        ifa.tx_push = push;               ifb.tx_push = push;
        ifa.credit_return = ret;          ifb.credit_return = ret;
    endtask

    task automatic model_reset();
        k_tx = -1; m_credit = 8'd0; m_ufl = 0; m_ofl = 0;
        m_rxd = 0; rx_armed = 0; rx_cnt = 0;
    endtask

    task automatic model_edge();
        int thr;
        bit was_on;
        thr = x + y + 1;
        was_on = (k_tx >= thr);
        if (!tx_on) begin
            k_tx = -1; m_credit = 8'd0; m_ufl = 0; m_ofl = 0;
        end else begin
            if (k_tx < 1000000) k_tx++;
            if (k_tx == thr) m_credit = init;
            else if (was_on) begin
                if (push && !ret) begin
                    if (m_credit == 8'd0) m_ufl = 1; else m_credit = m_credit - 8'd1;
                end else if (ret && !push) begin
                    if (m_credit == 8'd255) m_ofl = 1; else m_credit = m_credit + 8'd1;
                end
            end
        end
        if (!rx_on) begin
            m_rxd = 0; rx_cnt = 0; rx_armed = 0;
        end else if (hold) begin
            rx_cnt = 0; rx_armed = 1;
        end else if (!rx_armed) begin
            rx_armed = 1;
        end else begin
            rx_cnt++;
            if (rx_cnt >= z + 1) m_rxd = 1;
        end
    endtask

    task automatic check_all();
        int thr;
        bit on, synced;
        logic [1:0] st;
        logic [31:0] dbg;
        thr    = x + y + 1;
        on     = (k_tx >= thr);
        synced = (k_tx >= x + 1);
        st     = (k_tx < 0) ? 2'd0 : (k_tx <= x) ? 2'd1 : (k_tx < thr) ? 2'd2 : 2'd3;
        dbg    = {m_credit, 2'b00, st, on, m_rxd, m_ufl, m_ofl, 16'h0000};
        chk("a_txd",   ifa.tx_online_delay, on);
        chk("a_rxd",   ifa.rx_online_delay, m_rxd);
        chk("a_mrk",   ifa.tx_auto_mrk_userbit, synced ? mrk : 4'h0);
        chk("a_stb",   ifa.tx_auto_stb_userbit, synced & stb);
        chk("a_avail", ifa.tx_credit_avail, on && (m_credit != 8'd0));
        chk("a_dbg",   ifa.debug_status, dbg);
        chk("b_txd",   ifb.tx_online_delay, on);
        chk("b_mrk",   ifb.tx_auto_mrk_userbit, (synced && !on) ? mrk[1:0] : 2'b00);
        chk("b_stb",   ifb.tx_auto_stb_userbit, synced && !on && stb);
        chk("b_dbg",   ifb.debug_status, dbg);
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_a_txd"}, ifa.tx_online_delay, 0);
        chk({pfx, "_a_rxd"}, ifa.rx_online_delay, 0);
        chk({pfx, "_a_mrk"}, ifa.tx_auto_mrk_userbit, 0);
        chk({pfx, "_a_stb"}, ifa.tx_auto_stb_userbit, 0);
        chk({pfx, "_a_avail"}, ifa.tx_credit_avail, 0);
        chk({pfx, "_a_dbg"}, ifa.debug_status, 0);
        chk({pfx, "_b_mrk"}, ifb.tx_auto_mrk_userbit, 0);
        chk({pfx, "_b_dbg"}, ifb.debug_status, 0);
    endtask

    initial begin
        tx_on = 0; rx_on = 0; hold = 0; push = 0; ret = 0; stb = 1;
        x = 3; y = 2; z = 0; mrk = 4'hF; init = 8'd3;
        drive();
        model_reset();
        #7;
        check_zero("reset");
        #5 rst = 1'b0;

        // 1: X=3, Y=2 -> markers 4 edges and online 6 edges after the enable edge
        repeat (3) step();
        tx_on = 1;
        step();
        first_a = -1; first_b = -1;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (first_a < 0 && ifa.tx_auto_mrk_userbit != 4'h0) first_a = j;
            if (first_b < 0 && ifa.tx_online_delay) first_b = j;
        end
        chk("t1_mrk_first", first_a, 4);
        chk("t1_online_first", first_b, 6);
        // 3: non-persistent half-rate markers are gone once online
        chk("t3_b_mrk_online", ifb.tx_auto_mrk_userbit, 2'b00);
        chk("t3_a_mrk_online", ifa.tx_auto_mrk_userbit, 4'hF);

        // 2: X=Y=Z=0 -> everything one edge after the enable
        tx_on = 0; step();
        x = 0; y = 0; z = 0; init = 8'd2; step();
        tx_on = 1; rx_on = 1; step();
        chk("t2_txd_at_n", ifa.tx_online_delay, 0);
        step();
        chk("t2_txd", ifa.tx_online_delay, 1);
        chk("t2_rxd", ifa.rx_online_delay, 1);
        chk("t2_mrk", ifa.tx_auto_mrk_userbit, 4'hF);

        // 4: credit 2, three pushes -> 1, 0, 0 with underflow
        push = 1;
        repeat (3) step();
        push = 0;
        chk("t4_credit", ifa.debug_status[31:24], 8'd0);
        chk("t4_ufl", ifa.debug_status[17], 1'b1);
        chk("t4_avail", ifa.tx_credit_avail, 1'b0);

        // 5: saturation at 255 and simultaneous push/return
        tx_on = 0; step();
        init = 8'd254; tx_on = 1; step(); step();
        ret = 1; step(); step();
        chk("t5_credit_sat", ifa.debug_status[31:24], 8'd255);
        chk("t5_ofl", ifa.debug_status[16], 1'b1);
        push = 1; step();
        chk("t5_both", ifa.debug_status[31:24], 8'd255);
        ret = 0; step();
        chk("t5_after_push", ifa.debug_status[31:24], 8'd254);
        chk("t5_ofl_sticky", ifa.debug_status[16], 1'b1);
        push = 0;

        // 6: Z=5 with a holdoff pulse at count 3; TX dropped during SYNC
        tx_on = 0; rx_on = 0; step();
        z = 5; x = 3; y = 3; rx_on = 1; tx_on = 1; step();
        repeat (3) step();
        hold = 1; step();
        hold = 0;
        first_r = -1;
        for (int j = 5; j <= 12; j++) begin
            if (j == 6) tx_on = 0;
            step();
            if (j == 6) begin
                chk("t6_tx_idle", ifa.debug_status[21:20], 2'd0);
                chk("t6_mrk_idle", ifa.tx_auto_mrk_userbit, 4'h0);
            end
            if (first_r < 0 && ifa.rx_online_delay) first_r = j;
        end
        chk("t6_rx_first", first_r, 10);
        hold = 1; step();
        chk("t6_holdoff_keeps", ifa.rx_online_delay, 1'b1);
        hold = 0;

        // 7: reset while online
        x = 0; y = 0; init = 8'd5; step();
        tx_on = 1; repeat (3) step();
        chk("t7_pre_online", ifa.tx_online_delay, 1'b1);
        #3 rst = 1'b1;
        #1 check_zero("midrst");
        tx_on = 0; rx_on = 0; drive();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (tx_on) begin
                if ($urandom_range(0, 99) < 4) tx_on = 0;
            end else begin
                x = $urandom_range(0, 4); y = $urandom_range(0, 4);
                if ($urandom_range(0, 99) < 30) tx_on = 1;
            end
            if (rx_on) begin
                if ($urandom_range(0, 99) < 4) rx_on = 0;
            end else begin
                z = $urandom_range(0, 6);
                if ($urandom_range(0, 99) < 30) rx_on = 1;
            end
            hold = ($urandom_range(0, 99) < 8);
            push = ($urandom_range(0, 99) < 40);
            ret  = ($urandom_range(0, 99) < 40);
            mrk  = 4'($urandom);
            stb  = 1'($urandom);
            init = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3))
                                                : 8'($urandom_range(250, 255));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
